pong_score_ctrl: RTL and testbench

- Game-flow controller for Pong; sits directly upstream of the two-digit BCD score counter and drives its d_inc/d_clr inputs.
- Consumes hit/miss event pulses from the graphics engine, the start button and a per-frame tick.
- Tracks remaining balls, runs the serve and game-over delay timer, and freezes the graphics between rallies.

---
 rtl/pong_score_ctrl.sv | 143 ++++++++++++++
 tb/tb_pong_score_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pong_score_ctrl.sv
// Pong game-flow controller: serves balls, counts remaining balls, times the
// pause after a miss and drives the clear/increment inputs of the score counter.
module pong_score_ctrl #(
    parameter int unsigned BALLS        = 3,
    parameter int unsigned BALL_W       = 2,
    parameter int unsigned TIMER_FRAMES = 120,
    parameter int unsigned TIMER_W      = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              hit,
    input  logic              miss,
    input  logic              frame_tick,
    output logic              d_inc,
    output logic              d_clr,
    output logic              ball_reload,
    output logic              gra_still,
    output logic              game_over,
    output logic [BALL_W-1:0] balls_left
);

    localparam logic [1:0] ST_NEWGAME = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_NEWBALL = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    localparam logic [BALL_W-1:0]  BALLS_FULL  = BALL_W'(BALLS);
    localparam logic [BALL_W-1:0]  BALLS_SERVE = BALL_W'(BALLS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(TIMER_FRAMES);

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [BALL_W-1:0]  balls_q, balls_d;
    logic               start_q;
    logic               armed_q;
    logic               d_inc_q, d_inc_d;
    logic               d_clr_q, d_clr_d;
    logic               reload_q, reload_d;
    logic               still_q, over_q;
    logic               start_re;
    logic               timer_up;
    logic               timer_load;

    // Start edge detect; armed_q blocks a button held high through reset
    // release until it has been seen low once.
    always_comb begin
        start_re = btn_start & ~start_q & armed_q;
        timer_up = (timer_q == '0);
    end

    // Next-state, ball accounting and pulse generation.
    always_comb begin
        state_d    = state_q;
        balls_d    = balls_q;
        d_inc_d    = 1'b0;
        d_clr_d    = 1'b0;
        reload_d   = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                if (start_re) begin
                    d_clr_d  = 1'b1;
                    reload_d = 1'b1;
                    balls_d  = BALLS_SERVE;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (miss) begin
                    timer_load = 1'b1;
                    if (balls_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        balls_d = balls_q - BALL_W'(1);
                        state_d = ST_NEWBALL;
                    end
                end else if (hit) begin
                    d_inc_d = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (timer_up && start_re) begin
                    reload_d = 1'b1;
                    state_d  = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (timer_up) begin
                    balls_d = BALLS_FULL;
                    state_d = ST_NEWGAME;
                end
            end
            default: state_d = ST_NEWGAME;
        endcase
    end

    // Delay timer: load on entry to NEWBALL/OVER beats a coincident tick.
    always_comb begin
        timer_d = timer_q;
        if (timer_load) begin
            timer_d = TIMER_LOAD;
        end else if (frame_tick && !timer_up) begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    // State and output registers; level outputs follow the next state so they
    // line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_NEWGAME;
            timer_q  <= '0;
            balls_q  <= BALLS_FULL;
            start_q  <= 1'b0;
            armed_q  <= 1'b0;
            d_inc_q  <= 1'b0;
            d_clr_q  <= 1'b0;
            reload_q <= 1'b0;
            still_q  <= 1'b1;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            balls_q  <= balls_d;
            start_q  <= btn_start;
            armed_q  <= armed_q | ~btn_start;
            d_inc_q  <= d_inc_d;
            d_clr_q  <= d_clr_d;
            reload_q <= reload_d;
            still_q  <= (state_d != ST_PLAY);
            over_q   <= (state_d == ST_OVER);
        end
    end

    assign d_inc       = d_inc_q;
    assign d_clr       = d_clr_q;
    assign ball_reload = reload_q;
    assign gra_still   = still_q;
    assign game_over   = over_q;
    assign balls_left  = balls_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Bench for pong_score_ctrl: table of per-cycle vectors with hand-derived
// expected outputs, routed through a scoreboard queue, plus an async-reset case.
module tb_pong_score_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, hit, miss, frame_tick;
    logic       d_inc, d_clr, ball_reload, gra_still, game_over;
    logic [1:0] balls_left;

    pong_score_ctrl #(
        .BALLS       (3),
        .BALL_W      (2),
        .TIMER_FRAMES(4),
        .TIMER_W     (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .hit        (hit),
        .miss       (miss),
        .frame_tick (frame_tick),
        .d_inc      (d_inc),
        .d_clr      (d_clr),
        .ball_reload(ball_reload),
        .gra_still  (gra_still),
        .game_over  (game_over),
        .balls_left (balls_left)
    );

    always #5 clk = ~clk;

    // exp = {d_inc, d_clr, ball_reload, gra_still, game_over, balls_left[1:0]}
    typedef struct {
        string      name;
        logic       rst, btn, hit, miss, tick;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        int         idx;
        logic [6:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic add(input string name, input logic rst, input logic btn,
                       input logic h, input logic m, input logic t,
                       input logic e_inc, input logic e_clr, input logic e_rel,
                       input logic e_still, input logic e_over, input logic [1:0] e_balls);
        vec_t v;
        v.name = name; v.rst = rst; v.btn = btn; v.hit = h; v.miss = m; v.tick = t;
        v.exp  = {e_inc, e_clr, e_rel, e_still, e_over, e_balls};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [6:0] act,
                         input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got {inc,clr,rel,still,over,balls}=%b want %b",
                     name, idx, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {d_inc, d_clr, ball_reload, gra_still, game_over, balls_left};
    endfunction

    initial begin
        sb_t s;
        reset = 1'b1; btn_start = 1'b0; hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;

        // --- vector table ---
        add("reset",        1,0,0,0,0, 0,0,0,1,0,3);
        add("ng_idle",      0,0,0,0,0, 0,0,0,1,0,3);
        add("ng_hit",       0,0,1,0,0, 0,0,0,1,0,3);
        add("ng_miss",      0,0,0,1,0, 0,0,0,1,0,3);
        add("start",        0,1,0,0,0, 0,1,1,0,0,2);
        add("start_held",   0,1,0,0,0, 0,0,0,0,0,2);
        add("start_rel",    0,0,0,0,0, 0,0,0,0,0,2);
        for (int i = 0; i < 5; i++) begin
            add("play_hit",  0,0,1,0,0, 1,0,0,0,0,2);
            add("play_gap1", 0,0,0,0,0, 0,0,0,0,0,2);
            add("play_gap2", 0,0,0,0,0, 0,0,0,0,0,2);
        end
        add("hit_and_miss", 0,0,1,1,0, 0,0,0,1,0,1);
        add("nb_tick1",     0,0,0,0,1, 0,0,0,1,0,1);
        add("nb_tick2",     0,0,0,0,1, 0,0,0,1,0,1);
        add("nb_early_btn", 0,1,0,0,0, 0,0,0,1,0,1);
        add("nb_hit",       0,0,1,0,0, 0,0,0,1,0,1);
        add("nb_tick3",     0,0,0,0,1, 0,0,0,1,0,1);
        add("nb_tick4",     0,0,0,0,1, 0,0,0,1,0,1);
        add("nb_not_remem", 0,0,0,0,0, 0,0,0,1,0,1);
        add("nb_serve",     0,1,0,0,0, 0,0,1,0,0,1);
        add("serve_rel",    0,0,0,0,0, 0,0,0,0,0,1);
        add("miss_w_tick",  0,0,0,1,1, 0,0,0,1,0,0);
        for (int i = 0; i < 3; i++)
            add("nb2_tick",  0,0,0,0,1, 0,0,0,1,0,0);
        add("nb2_btn_t1",   0,1,0,0,0, 0,0,0,1,0,0);
        add("nb2_rel",      0,0,0,0,0, 0,0,0,1,0,0);
        add("nb2_tick4",    0,0,0,0,1, 0,0,0,1,0,0);
        add("nb2_serve",    0,1,0,0,0, 0,0,1,0,0,0);
        add("serve2_rel",   0,0,0,0,0, 0,0,0,0,0,0);
        add("miss_last",    0,0,0,1,0, 0,0,0,1,1,0);
        add("over_hit",     0,0,1,0,0, 0,0,0,1,1,0);
        add("over_btn",     0,1,0,0,0, 0,0,0,1,1,0);
        add("over_rel",     0,0,0,0,0, 0,0,0,1,1,0);
        for (int i = 0; i < 4; i++)
            add("over_tick", 0,0,0,0,1, 0,0,0,1,1,0);
        add("over_exit",    0,0,0,0,0, 0,0,0,1,0,3);
        add("ng2_idle",     0,0,0,0,0, 0,0,0,1,0,3);
        add("ng2_hit",      0,0,1,0,0, 0,0,0,1,0,3);
        add("hold_start",   0,1,0,0,0, 0,1,1,0,0,2);
        for (int i = 0; i < 49; i++)
            add("hold",      0,1,0,0,0, 0,0,0,0,0,2);
        add("hold_rel",     0,0,0,0,0, 0,0,0,0,0,2);
        add("rst_w_hit",    1,0,1,0,0, 0,0,0,1,0,3);
        add("rst_w_btn",    1,1,0,0,0, 0,0,0,1,0,3);
        for (int i = 0; i < 3; i++)
            add("btn_thru_rst", 0,1,0,0,0, 0,0,0,1,0,3);
        add("btn_released", 0,0,0,0,0, 0,0,0,1,0,3);
        add("btn_repress",  0,1,0,0,0, 0,1,1,0,0,2);
        add("repress_rel",  0,0,0,0,0, 0,0,0,0,0,2);

        // --- apply: push expectation on drive, pop and compare after the edge ---
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            btn_start  = vecs[i].btn;
            hit        = vecs[i].hit;
            miss       = vecs[i].miss;
            frame_tick = vecs[i].tick;
            s.name = vecs[i].name; s.idx = i; s.exp = vecs[i].exp;
            sb.push_back(s);
            @(posedge clk);
            #1;
            s = sb.pop_front();
            check(s.name, s.idx, outs(), s.exp);
        end

        // --- async reset drops an in-flight d_inc immediately ---
        @(negedge clk);
        btn_start = 1'b0; hit = 1'b1;
        @(posedge clk);
        #1;
        check("inc_before_rst", 0, outs(), 7'b1000010);
        reset = 1'b1;
        #1;
        check("async_rst", 0, outs(), 7'b0001011);
        hit = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_async_rst", 0, outs(), 7'b0001011);

        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
